run_ctrl: RTL

Run sequencer and data-memory arbiter for the Pebble core. It holds the core in reset until `start` arrives, then issues a clean reset pulse and enables execution. It counts executed cycles, detects core `done` or a watchdog timeout, and hands data_mem to a host port (loader/bench) whenever the core is not running.

---
 rtl/pebble_pkg.sv | 14 +
 rtl/mem_port_mux.sv | 37 +++
 rtl/run_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pebble_pkg.sv
// Shared types and bus widths for the Pebble core slice.
package pebble_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } run_state_e;

endpackage

// File: rtl/mem_port_mux.sv
// Data-memory port selector: core owns the bus while running, host otherwise.
module mem_port_mux #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          run_owns_mem,
  input  logic          host_allowed,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  // Host address is the idle default so a denied host still sees its read address.
  always_comb begin
    host_gnt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    if (run_owns_mem) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_allowed) begin
      mem_we   = host_req & host_we;
      host_gnt = host_req;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer for the Pebble core: reset pulse, run window, cycle count,
// watchdog, and data-memory ownership.
module run_ctrl
  import pebble_pkg::*;
#(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned AW         = ADDR_W,
  parameter int unsigned DW         = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  input  logic             core_we,
  input  logic [AW-1:0]    core_addr,
  input  logic [DW-1:0]    core_wdata,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_gnt,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata
);

  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  run_state_e       state, state_d;
  logic [CLR_W-1:0] clr_cnt, clr_cnt_d;
  logic [CNT_W-1:0] cycles_d, cycles_inc;
  logic             done_d, timeout_d;

  // State and run bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
      cycles  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
      cycles  <= cycles_d;
      done    <= done_d;
      timeout <= timeout_d;
    end
  end

  // Next-state and counter update; core_done outranks the watchdog.
  always_comb begin
    state_d    = state;
    clr_cnt_d  = clr_cnt;
    cycles_d   = cycles;
    done_d     = done;
    timeout_d  = timeout;
    cycles_inc = cycles + CNT_W'(1);
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          cycles_d  = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt + CLR_W'(1);
        end
      end
      RUN: begin
        cycles_d = cycles_inc;
        if (core_done) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (cycles_inc == CNT_W'(TIMEOUT)) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign core_reset = (state == IDLE) || (state == CLEAR);
  assign core_en    = (state == RUN);
  assign busy       = (state == CLEAR) || (state == RUN);

  // Reset also gates the host path so no write slips through while it is held.
  mem_port_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mem_port_mux (
    .run_owns_mem (state == RUN),
    .host_allowed (((state == IDLE) || (state == FINISH)) && !reset),
    .core_we      (core_we),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata)
  );

endmodule
